// File: rtl/frame_mean_threshold_if.sv
// Pixel stream, threshold controls and status between the frame source
// and the frame-mean threshold generator.
interface frame_mean_threshold_if;
    logic       iFrameStart;
    logic       iValid;
    logic [7:0] iGray;
    logic       iAuto;
    logic [7:0] iManualThreshold;
    logic [7:0] iOffset;
    logic [7:0] oThreshold;
    logic [7:0] oMean;
    logic       oUpdate;
    logic       oBusy;
    logic       oOverflow;

    modport master (
        output iFrameStart, iValid, iGray, iAuto, iManualThreshold, iOffset,
        input  oThreshold, oMean, oUpdate, oBusy, oOverflow
    );

    modport slave (
        input  iFrameStart, iValid, iGray, iAuto, iManualThreshold, iOffset,
        output oThreshold, oMean, oUpdate, oBusy, oOverflow
    );
endinterface

// File: rtl/frame_mean_threshold.sv
// Per-frame mean of pixel luminance via an iterative restoring divider,
// driving a registered auto (mean + offset) or manual binarisation threshold.
module frame_mean_threshold #(
    parameter int         COUNT_W        = 20,
    parameter logic [7:0] DEFAULT_THRESH = 8'd128
) (
    input logic                  iClk,
    input logic                  iReset,
    frame_mean_threshold_if.slave bus
);

    localparam int SUM_W  = COUNT_W + 8;
    localparam int ITER_W = $clog2(SUM_W);
    localparam logic [COUNT_W-1:0] MAX_COUNT = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]         state;
    logic [SUM_W-1:0]   sum;
    logic [COUNT_W-1:0] count;
    logic               satFlag;
    logic [SUM_W-1:0]   dividend;
    logic [COUNT_W-1:0] divisor;
    logic               snapFlag;
    logic [SUM_W-1:0]   remainder;
    logic [ITER_W-1:0]  iter;

    logic [SUM_W:0]     remShift;
    logic [SUM_W:0]     divisorExt;
    logic               quotBit;
    logic [SUM_W-1:0]   nextRem;
    logic [SUM_W-1:0]   nextDividend;
    logic [9:0]         autoSum;
    logic [7:0]         autoThresh;
    logic [7:0]         grayIn;

    assign grayIn    = bus.iValid ? bus.iGray : 8'd0;
    assign bus.oBusy = (state == DIVIDE);

    // The dividend register doubles as the quotient: one bit shifts out, one in.
    always_comb begin
        remShift     = {remainder, dividend[SUM_W-1]};
        divisorExt   = {9'd0, divisor};
        quotBit      = (remShift >= divisorExt);
        nextRem      = quotBit ? SUM_W'(remShift - divisorExt) : remShift[SUM_W-1:0];
        nextDividend = {dividend[SUM_W-2:0], quotBit};
    end

    always_comb begin
        autoSum = {2'b00, bus.oMean} + {{2{bus.iOffset[7]}}, bus.iOffset};
        if (autoSum[9])
            autoThresh = 8'd0;
        else if (autoSum[8])
            autoThresh = 8'hFF;
        else
            autoThresh = autoSum[7:0];
    end

    // A pixel arriving with the frame-start pulse opens the new frame's sums.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            sum     <= '0;
            count   <= '0;
            satFlag <= 1'b0;
        end else if (bus.iFrameStart) begin
            sum     <= SUM_W'(grayIn);
            count   <= COUNT_W'(bus.iValid);
            satFlag <= 1'b0;
        end else if (bus.iValid) begin
            if (count != MAX_COUNT) begin
                sum   <= sum + SUM_W'(bus.iGray);
                count <= count + COUNT_W'(1);
            end else begin
                satFlag <= 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state         <= IDLE;
            dividend      <= '0;
            divisor       <= '0;
            snapFlag      <= 1'b0;
            remainder     <= '0;
            iter          <= '0;
            bus.oMean     <= DEFAULT_THRESH;
            bus.oUpdate   <= 1'b0;
            bus.oOverflow <= 1'b0;
        end else begin
            bus.oUpdate <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iFrameStart && count != '0) begin
                        dividend  <= sum;
                        divisor   <= count;
                        snapFlag  <= satFlag;
                        remainder <= '0;
                        iter      <= '0;
                        state     <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    remainder <= nextRem;
                    dividend  <= nextDividend;
                    iter      <= iter + ITER_W'(1);
                    // Results land with the DONE transition so they are visible during DONE.
                    if (iter == ITER_W'(SUM_W - 1)) begin
                        bus.oMean     <= nextDividend[7:0];
                        bus.oOverflow <= snapFlag;
                        bus.oUpdate   <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset)
            bus.oThreshold <= DEFAULT_THRESH;
        else
            bus.oThreshold <= bus.iAuto ? autoThresh : bus.iManualThreshold;
    end

endmodule

// File: tb/tb_frame_mean_threshold.sv
// Bench for frame_mean_threshold: a wide and a saturating instance share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_frame_mean_threshold;

    logic       iClk = 1'b0;
    logic       iReset = 1'b1;
    logic       fs = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] gray = 8'd0;
    logic       autoMode = 1'b1;
    logic [7:0] manThr = 8'd0;
    logic [7:0] offset = 8'd0;

    always #5 iClk = ~iClk;

    frame_mean_threshold_if busA ();
    frame_mean_threshold_if busB ();

    assign busA.iFrameStart = fs;
    assign busA.iValid = valid;
    assign busA.iGray = gray;
    assign busA.iAuto = autoMode;
    assign busA.iManualThreshold = manThr;
    assign busA.iOffset = offset;
    assign busB.iFrameStart = fs;
    assign busB.iValid = valid;
    assign busB.iGray = gray;
    assign busB.iAuto = autoMode;
    assign busB.iManualThreshold = manThr;
    assign busB.iOffset = offset;

    frame_mean_threshold #(.COUNT_W(20), .DEFAULT_THRESH(8'd128)) dut (
        .iClk(iClk), .iReset(iReset), .bus(busA)
    );

    frame_mean_threshold #(.COUNT_W(4), .DEFAULT_THRESH(8'd128)) dutSat (
        .iClk(iClk), .iReset(iReset), .bus(busB)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    int maxCnt[2] = '{1048575, 15};
    int sumW[2]   = '{28, 12};
    int mSum[2], mCnt[2], doneEdge[2], pendMean[2], mean[2], thr[2];
    bit mSat[2], divActive[2], pendOvf[2], ovf[2], upd[2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Frame-level reference: frame sum/count by plain arithmetic, and the
    // mean published sumW cycles after a frame start that finds the divider free.
    task automatic modelStep(input int k);
        int newThr;
        int o;
        upd[k] = 1'b0;
        if (iReset) begin
            mSum[k] = 0; mCnt[k] = 0; mSat[k] = 1'b0; divActive[k] = 1'b0;
            mean[k] = 128; thr[k] = 128; ovf[k] = 1'b0;
            return;
        end
        o = $signed(offset);
        if (autoMode) begin
            newThr = mean[k] + o;
            if (newThr < 0) newThr = 0;
            else if (newThr > 255) newThr = 255;
        end else begin
            newThr = manThr;
        end
        if (divActive[k] && cycle == doneEdge[k]) begin
            upd[k] = 1'b1;
            mean[k] = pendMean[k];
            ovf[k] = pendOvf[k];
        end
        if (fs) begin
            if ((!divActive[k] || cycle > doneEdge[k] + 1) && mCnt[k] > 0) begin
                pendMean[k] = mSum[k] / mCnt[k];
                pendOvf[k] = mSat[k];
                divActive[k] = 1'b1;
                doneEdge[k] = cycle + sumW[k];
            end
            mSum[k] = valid ? int'(gray) : 0;
            mCnt[k] = valid ? 1 : 0;
            mSat[k] = 1'b0;
        end else if (valid) begin
            if (mCnt[k] < maxCnt[k]) begin
                mSum[k] += gray;
                mCnt[k]++;
            end else begin
                mSat[k] = 1'b1;
            end
        end
        thr[k] = newThr;
    endtask

    task automatic checkDut(input string name, input int k, input logic [7:0] m, input logic [7:0] th,
                            input logic u, input logic b, input logic o);
        checkOutput({name, ".oMean"}, m, mean[k]);
        checkOutput({name, ".oThreshold"}, th, thr[k]);
        checkOutput({name, ".oUpdate"}, u, upd[k]);
        checkOutput({name, ".oBusy"}, b, divActive[k] && cycle < doneEdge[k]);
        checkOutput({name, ".oOverflow"}, o, ovf[k]);
    endtask

    task automatic applyStimulus(input bit r, input bit f, input bit v, input int g);
        iReset = r;
        fs = f;
        valid = v;
        gray = g[7:0];
        @(posedge iClk);
        cycle++;
        modelStep(0);
        modelStep(1);
        #1;
        checkDut("dut", 0, busA.oMean, busA.oThreshold, busA.oUpdate, busA.oBusy, busA.oOverflow);
        checkDut("dutSat", 1, busB.oMean, busB.oThreshold, busB.oUpdate, busB.oBusy, busB.oOverflow);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic pixels(input int n, input int g);
        repeat (n) applyStimulus(0, 0, 1, g);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("resetMean", busA.oMean, 128);
        checkOutput("resetThresh", busA.oThreshold, 128);
        checkOutput("resetBusy", busA.oBusy, 0);
        checkOutput("resetUpdate", busA.oUpdate, 0);
        checkOutput("resetOverflow", busA.oOverflow, 0);

        applyStimulus(0, 1, 0, 0);
        pixels(16, 100);
        applyStimulus(0, 1, 0, 0);
        idle(28);
        checkOutput("uniformUpdate", busA.oUpdate, 1);
        checkOutput("uniformMean", busA.oMean, 100);
        idle(1);
        checkOutput("uniformThresh", busA.oThreshold, 100);
        idle(2);

        pixels(2, 0);
        pixels(1, 255);
        applyStimulus(0, 1, 0, 0);
        idle(31);
        checkOutput("mixedMean", busA.oMean, 85);
        offset = 8'd120;
        idle(2);
        checkOutput("offsetHigh", busA.oThreshold, 205);
        offset = 8'd156;
        idle(2);
        checkOutput("offsetLow", busA.oThreshold, 0);
        offset = 8'd10;
        pixels(3, 250);
        applyStimulus(0, 1, 0, 0);
        idle(31);
        checkOutput("clampTop", busA.oThreshold, 255);

        applyStimulus(0, 1, 0, 0);
        idle(3);
        applyStimulus(0, 1, 0, 0);
        idle(3);
        checkOutput("emptyBusy", busA.oBusy, 0);
        idle(30);
        checkOutput("emptyMean", busA.oMean, 250);

        pixels(2, 10);
        applyStimulus(0, 1, 1, 50);
        pixels(1, 20);
        idle(30);
        checkOutput("coincidentOld", busA.oMean, 10);
        applyStimulus(0, 1, 0, 0);
        idle(31);
        checkOutput("coincidentNew", busA.oMean, 35);

        pixels(4, 60);
        applyStimulus(0, 1, 0, 0);
        pixels(4, 200);
        applyStimulus(0, 1, 0, 0);
        pixels(6, 30);
        idle(20);
        checkOutput("overlapMean", busA.oMean, 60);
        applyStimulus(0, 1, 0, 0);
        idle(31);
        checkOutput("frameCMean", busA.oMean, 30);

        pixels(2, 40);
        applyStimulus(0, 1, 0, 0);
        autoMode = 1'b0;
        manThr = 8'd37;
        idle(1);
        checkOutput("manualThresh", busA.oThreshold, 37);
        checkOutput("manualBusy", busA.oBusy, 1);
        idle(30);
        autoMode = 1'b1;
        offset = 8'd0;

        applyStimulus(0, 1, 0, 0);
        pixels(20, 10);
        applyStimulus(0, 1, 0, 0);
        idle(12);
        checkOutput("satUpdate", busB.oUpdate, 1);
        checkOutput("satMean", busB.oMean, 10);
        checkOutput("satOverflow", busB.oOverflow, 1);
        idle(20);
        checkOutput("wideOverflow", busA.oOverflow, 0);

        for (int f = 0; f < 60; f++) begin
            int len;
            if ($urandom_range(0, 19) == 0) applyStimulus(1, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) autoMode = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) offset = 8'($urandom);
            if ($urandom_range(0, 3) == 0) manThr = 8'($urandom);
            len = $urandom_range(0, 40);
            for (int i = 0; i < len; i++)
                applyStimulus(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 255));
            applyStimulus(0, 1, $urandom_range(0, 1), $urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) idle(35);
        end
        idle(35);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_mean_threshold.md
# frame_mean_threshold

Generates the 8-bit binarisation threshold consumed by the delay thresholder stage. It accumulates the gray value of every valid pixel in a frame. At each frame boundary it divides the sum by the pixel count with an iterative restoring divider. It then drives the threshold output from either the frame mean plus a signed offset (auto mode) or a manual value.

## Interface
- COUNT_W, 20, width of the per-frame pixel counter; the maximum count is 2^COUNT_W-1.
- DEFAULT_THRESH, 128, reset value of oMean and oThreshold.
- SUM_W (localparam), COUNT_W+8, accumulator and divider width.

Ports:
- iClk  in  1  single clock for all logic.
- iReset  in  1  reset, synchronous and active-high.
- iFrameStart  in  1  one-cycle pulse marking the first cycle of a frame.
- iValid  in  1  qualifies iGray.
- iGray  in  8  pixel luminance.
- iAuto  in  1  1 = auto threshold from the frame mean, 0 = manual.
- iManualThreshold  in  8  threshold used when iAuto=0.
- iOffset  in  8  signed two's-complement offset added to the mean in auto mode.
- oThreshold  out  8  registered threshold to the thresholder.
- oMean  out  8  mean of the last completed frame.
- oUpdate  out  1  one-cycle pulse when oMean is loaded.
- oBusy  out  1  high while the divider runs.
- oOverflow  out  1  pixel counter saturated in the frame whose mean was last loaded.

## Operation
- Accumulator (sum, SUM_W bits) and counter (count, COUNT_W bits) run continuously.
- iValid=1 and count < 2^COUNT_W-1: sum += iGray, count += 1.
- iValid=1 and count saturated: pixel ignored (not summed), frame saturation flag set.
- On iFrameStart:
  - The accumulators load the current pixel: iValid ? iGray : 0 and iValid ? 1 : 0. A pixel coincident with iFrameStart belongs to the new frame.
  - The saturation flag clears.
  - If state is IDLE and the old count > 0: snapshot sum, count and the saturation flag, then enter DIVIDE.
  - If the old count = 0: no division; oMean holds.
  - If state is DIVIDE: the snapshot is discarded and the division in progress continues unaffected.
- States:
  - IDLE: waits for iFrameStart.
  - DIVIDE: SUM_W restoring iterations, one per cycle, MSB first, remainder SUM_W+1 bits.
  - DONE: one cycle; loads oMean = quotient[7:0] (quotient is always ≤255), oOverflow = snapshot flag, pulses oUpdate; then IDLE.
- oBusy = 1 exactly while in DIVIDE.
- Threshold computation, registered every cycle:
  - iAuto=1: oThreshold = clamp(oMean + sign_extend(iOffset), 0, 255), computed in 10-bit signed arithmetic.
  - iAuto=0: oThreshold = iManualThreshold.
- Reset: state IDLE, sum=0, count=0, flag=0, oMean=DEFAULT_THRESH, oThreshold=DEFAULT_THRESH, oUpdate=0, oBusy=0, oOverflow=0. Reset during DIVIDE aborts the division; no oUpdate is produced.

## Timing
- iFrameStart sampled at edge T: oBusy=1 from T+1 through T+SUM_W.
- DONE occupies cycle T+SUM_W+1: oMean, oOverflow and oUpdate=1 are visible in that cycle, and oBusy=0.
- In auto mode oThreshold reflects the new mean one cycle later (T+SUM_W+2).
- With default COUNT_W: 28 divide cycles, total latency 30 cycles from iFrameStart to new oThreshold.
- Changes to iManualThreshold, iOffset or iAuto appear on oThreshold one cycle after being sampled, independent of oBusy.
- Frames shorter than SUM_W+2 cycles lose alternate means; this is accepted behaviour.

## Test plan
- Reset: assert iReset 2 cycles -> oMean=128, oThreshold=128, oBusy=0, oUpdate=0, oOverflow=0.
- Uniform frame: 16 valid pixels of 100, iAuto=1, iOffset=0, then iFrameStart -> oBusy for 28 cycles, oUpdate with oMean=100 at T+29, oThreshold=100 at T+30.
- Mixed frame with offset saturation:
  - Pixels 0, 0, 255: oMean=85.
  - iOffset=+120: oThreshold=205.
  - iOffset=-100: oThreshold=0.
  - oMean=250 with iOffset=+10: oThreshold=255.
- Boundaries:
  - Two iFrameStart pulses with no valid pixels between them -> oBusy stays 0, oMean unchanged.
  - iFrameStart coincident with a valid pixel of 50 -> that pixel is counted in the next frame's mean.
- Frame start during DIVIDE:
  - Frame A (mean 60), then frame B (4 pixels of 200) ending 5 cycles into A's division -> only A's oUpdate (oMean=60).
  - A following frame C (all 30) -> oMean=30.
- Manual mode and overflow:
  - iAuto=0, iManualThreshold=37 -> oThreshold=37 next cycle, also while oBusy=1.
  - COUNT_W=4: 20 pixels of 10 -> count saturates at 15, oMean=10, oOverflow=1 with oUpdate.
